// File: rtl/iop_pkg.sv
// Shared types and constants for the IOP pulse sequencer.
//   - iop_state_e : sequencer state encoding
//   - DEF_*_CYC   : default pulse/gap lengths in clock cycles
//   - MB_*        : bit positions of the instruction fields in mb
package iop_pkg;

    localparam int unsigned DEF_PULSE_CYC = 4;
    localparam int unsigned DEF_GAP_CYC   = 2;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MB_W       = 9;
    localparam int unsigned DEV_W      = 6;
    localparam int unsigned MB_DEV_MSB = 8;
    localparam int unsigned MB_DEV_LSB = 3;
    localparam int unsigned MB_IOP4    = 2;
    localparam int unsigned MB_IOP2    = 1;
    localparam int unsigned MB_IOP1    = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_P1,
        S_G1,
        S_P2,
        S_G2,
        S_P4,
        S_G4,
        S_DONE
    } iop_state_e;

endpackage

// File: rtl/iop_slot_timer.sv
// Loadable down-counter that times one pulse or gap slot.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val on this edge
//   load_val  : slot length minus one
//   zero      : registered flag, high during the final cycle of the slot
module iop_slot_timer
    import iop_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Zero is tracked alongside the count so it is available as a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
            zero  <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/iop_sequencer.sv
// IOT instruction sequencer: latches the device select and issues the
// IOP1/IOP2/IOP4 pulses in fixed slots, collecting skip / AC-clear responses.
//   clk, rst            : clock, async active-high reset
//   iot_start, mb       : start request and instruction bits
//   io_skip, io_ac_clr  : device responses (active-high)
//   iop1, iop2, iop4    : pulse commands
//   dev_sel, bus_en     : bus driver select and enable
//   busy, done          : sequence status and completion strobe
//   skip, ac_clr        : latched device responses
module iop_sequencer
    import iop_pkg::*;
#(
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iot_start,
    input  logic [MB_W-1:0]  mb,
    input  logic             io_skip,
    input  logic             io_ac_clr,
    output logic             iop1,
    output logic             iop2,
    output logic             iop4,
    output logic [DEV_W-1:0] dev_sel,
    output logic             bus_en,
    output logic             busy,
    output logic             done,
    output logic             skip,
    output logic             ac_clr
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    iop_state_e       state, state_n;
    logic [2:0]       en_q;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    iop_slot_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign accept = (state == S_IDLE) && iot_start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state; the timer is loaded on the edge that enters each slot
    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = PULSE_LD;
        case (state)
            S_IDLE:  if (iot_start) state_n = S_LATCH;
            S_LATCH: begin
                state_n  = S_P1;
                tmr_load = 1'b1;
            end
            S_P1: if (tmr_zero) begin
                state_n  = S_G1;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            S_G1: if (tmr_zero) begin
                state_n  = S_P2;
                tmr_load = 1'b1;
            end
            S_P2: if (tmr_zero) begin
                state_n  = S_G2;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            S_G2: if (tmr_zero) begin
                state_n  = S_P4;
                tmr_load = 1'b1;
            end
            S_P4: if (tmr_zero) begin
                state_n  = S_G4;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            S_G4:    if (tmr_zero) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they line up with the state itself.
    // dev_sel is loaded on the accepting edge, i.e. it is valid from LATCH on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= '0;
            dev_sel <= '0;
            iop1    <= 1'b0;
            iop2    <= 1'b0;
            iop4    <= 1'b0;
            bus_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            skip    <= 1'b0;
            ac_clr  <= 1'b0;
        end else begin
            if (accept) begin
                en_q    <= {mb[MB_IOP4], mb[MB_IOP2], mb[MB_IOP1]};
                dev_sel <= mb[MB_DEV_MSB:MB_DEV_LSB];
            end
            iop1   <= (state_n == S_P1) && en_q[0];
            iop2   <= (state_n == S_P2) && en_q[1];
            iop4   <= (state_n == S_P4) && en_q[2];
            bus_en <= (state_n != S_IDLE) && (state_n != S_DONE);
            busy   <= (state_n != S_IDLE);
            done   <= (state_n == S_DONE);
            // Responses only count while a pulse is actually on the bus
            if (accept) begin
                skip   <= 1'b0;
                ac_clr <= 1'b0;
            end else if (iop1 || iop2 || iop4) begin
                if (io_skip)   skip   <= 1'b1;
                if (io_ac_clr) ac_clr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iop_sequencer.sv
module tb_iop_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_f;
    logic [8:0] mb;
    logic       io_skip, io_ac_clr;

    logic       iop1_a, iop2_a, iop4_a, bus_en_a, busy_a, done_a, skip_a, ac_a;
    logic [5:0] dev_a;
    logic       iop1_f, iop2_f, iop4_f, bus_en_f, busy_f, done_f, skip_f, ac_f;
    logic [5:0] dev_f;

    always #5 clk = ~clk;

    iop_sequencer dut_a (
        .clk(clk), .rst(rst), .iot_start(start_a), .mb(mb),
        .io_skip(io_skip), .io_ac_clr(io_ac_clr),
        .iop1(iop1_a), .iop2(iop2_a), .iop4(iop4_a), .dev_sel(dev_a),
        .bus_en(bus_en_a), .busy(busy_a), .done(done_a),
        .skip(skip_a), .ac_clr(ac_a)
    );

    iop_sequencer #(.PULSE_CYC(1), .GAP_CYC(1)) dut_f (
        .clk(clk), .rst(rst), .iot_start(start_f), .mb(mb),
        .io_skip(io_skip), .io_ac_clr(io_ac_clr),
        .iop1(iop1_f), .iop2(iop2_f), .iop4(iop4_f), .dev_sel(dev_f),
        .bus_en(bus_en_f), .busy(busy_f), .done(done_f),
        .skip(skip_f), .ac_clr(ac_f)
    );

    // Observed vector: {iop1,iop2,iop4,bus_en,busy,done,skip,ac_clr,dev_sel}
    localparam logic [13:0] M_CTRL = 14'h3F00;
    localparam logic [13:0] M_RESP = 14'h00C0;
    localparam logic [13:0] M_DEV  = 14'h003F;

    typedef struct {
        logic [13:0] exp;
        logic [13:0] mask;
        int          cyc;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic logic [13:0] obs(input int dsel);
        if (dsel != 0)
            return {iop1_f, iop2_f, iop4_f, bus_en_f, busy_f, done_f, skip_f, ac_f, dev_f};
        return {iop1_a, iop2_a, iop4_a, bus_en_a, busy_a, done_a, skip_a, ac_a, dev_a};
    endfunction

    // Reference behaviour for cycle c after the cycle carrying the start (c = 0)
    function automatic logic [13:0] model(input int p, input int g, input logic [2:0] en,
                                          input logic [5:0] dev, input int c,
                                          input logic sk, input logic ac);
        int d;
        int s;
        int off;
        logic [2:0] pul;
        logic be, bz, dn;
        d   = 2 + 3 * (p + g);
        pul = 3'b000;
        be  = (c >= 1) && (c < d);
        bz  = (c >= 1) && (c <= d);
        dn  = (c == d);
        if (c >= 2 && c < d) begin
            s   = (c - 2) / (p + g);
            off = (c - 2) % (p + g);
            if (off < p) pul[s] = en[s];
        end
        return {pul[0], pul[1], pul[2], be, bz, dn, sk, ac, dev};
    endfunction

    task automatic check(input int dsel, input sb_t e);
        logic [13:0] o;
        o = obs(dsel);
        n_vec++;
        assert ((o & e.mask) === (e.exp & e.mask)) else begin
            n_err++;
            $error("FAIL %s cyc %0d: observed %h expected %h (mask %h)",
                   e.tag, e.cyc, o & e.mask, e.exp & e.mask, e.mask);
        end
    endtask

    task automatic drive(input int dsel, input logic s, input logic [8:0] m,
                         input logic sk, input logic ac);
        if (dsel != 0) start_f = s;
        else           start_a = s;
        mb        = m;
        io_skip   = sk;
        io_ac_clr = ac;
    endtask

    // One transaction: expectations queued when the start is driven, popped per cycle.
    // Caller must be positioned just after a falling edge. lim > 0 truncates the run.
    task automatic run(input string tag, input int dsel, input logic [8:0] m,
                       input logic [8:0] m_after, input logic [31:0] start_map,
                       input logic [31:0] skip_map, input logic [31:0] ac_map,
                       input logic exp_sk, input logic exp_ac, input int lim);
        int  p, g, d, n;
        sb_t e;
        p = (dsel != 0) ? 1 : 4;
        g = (dsel != 0) ? 1 : 2;
        d = 2 + 3 * (p + g);
        n = (lim > 0) ? lim : d + 1;
        for (int c = 1; c <= d + 1; c++) begin
            e.cyc  = c;
            e.tag  = tag;
            e.exp  = model(p, g, m[2:0], m[8:3], c,
                           (c >= d) ? exp_sk : 1'b0, (c >= d) ? exp_ac : 1'b0);
            e.mask = M_CTRL | ((c <= d) ? M_DEV : 14'h0)
                   | ((c == 1 || c >= d) ? M_RESP : 14'h0);
            sb_q.push_back(e);
        end
        drive(dsel, start_map[0], m, skip_map[0], ac_map[0]);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(dsel, e);
            end
            drive(dsel, start_map[k], m_after, skip_map[k], ac_map[k]);
        end
        sb_q.delete();
    endtask

    task automatic idle_check(input string tag, input int dsel, input int n);
        sb_t e;
        for (int i = 1; i <= n; i++) begin
            e.cyc  = i;
            e.tag  = tag;
            e.exp  = 14'h0;
            e.mask = M_CTRL | M_RESP;
            sb_q.push_back(e);
            @(negedge clk);
            e = sb_q.pop_front();
            check(dsel, e);
        end
    endtask

    task automatic zero_check(input string tag, input int dsel);
        sb_t e;
        e.cyc  = 0;
        e.tag  = tag;
        e.exp  = 14'h0;
        e.mask = 14'h3FFF;
        check(dsel, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start_a   = 1'b0;
        start_f   = 1'b0;
        mb        = 9'o000;
        io_skip   = 1'b0;
        io_ac_clr = 1'b0;
        repeat (2) @(negedge clk);
        zero_check("reset_a", 0);
        zero_check("reset_f", 1);
        rst = 1'b0;
        @(negedge clk);
        idle_check("idle_a", 0, 2);

        // All three pulses; ac_clr on the last cycle of the IOP4 pulse
        run("all3", 0, 9'o037, 9'o037, 32'h1, 32'h0, 32'h1 << 17, 1'b0, 1'b1, 0);
        // IOP2 only; skip during IOP2, ac_clr only in the disabled IOP1 slot
        run("iop2", 0, 9'o412, 9'o412, 32'h1, 32'h0000_0F00, 32'h0000_003C, 1'b1, 1'b0, 0);
        // Responses only outside pulses
        run("gap_rsp", 0, 9'o037, 9'o037, 32'h1,
            (32'h1 << 0) | (32'h1 << 6) | (32'h1 << 7) | (32'h1 << 20) | (32'h1 << 21),
            (32'h1 << 12) | (32'h1 << 13), 1'b0, 1'b0, 0);
        // Restarts while busy (P1 and DONE) are dropped
        run("busy_st", 0, 9'o037, 9'o037, 32'h1 | (32'h1 << 5) | (32'h1 << 20),
            32'h0, 32'h0, 1'b0, 1'b0, 0);
        // Start in the IDLE cycle right after DONE; mb changes afterwards
        run("idle_st", 0, 9'o255, 9'o772, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        // No enables: full-length silent sequence, responses ignored
        run("no_pul", 0, 9'o070, 9'o070, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        // Minimum slot lengths
        run("min_nop", 1, 9'o150, 9'o150, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        run("min_pul", 1, 9'o007, 9'o007, 32'h1, 32'h1 << 2, 32'h1 << 6, 1'b1, 1'b1, 0);

        // Reset in the middle of P2
        run("pre_rst", 0, 9'o037, 9'o037, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 9);
        #2 rst = 1'b1;
        #1;
        zero_check("rst_mid_a", 0);
        zero_check("rst_mid_f", 1);
        @(negedge clk);
        rst = 1'b0;
        idle_check("post_rst", 0, 3);
        run("fresh", 0, 9'o037, 9'o037, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iop_sequencer.md
IOP_SEQUENCER -- requirements
Module: iop_sequencer

Interface
REQ-001 Parameter PULSE_CYC, default 4: clock cycles each IOP pulse is asserted; legal range 1..15.
REQ-002 Parameter GAP_CYC, default 2: clock cycles of deasserted gap after each pulse slot; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 iot_start  input  1  one-cycle request to execute an IOT instruction.
REQ-006 mb  input  9  instruction bits: [8:3] device select, [2] IOP4 enable, [1] IOP2 enable, [0] IOP1 enable.
REQ-007 io_skip  input  1  device skip request; active-high, already inverted from the negative bus.
REQ-008 io_ac_clr  input  1  device AC-clear request; active-high.
REQ-009 iop1, iop2, iop4  output  1 each  pulse commands to the negative bus driver inputs.
REQ-010 dev_sel  output  6  latched device select, driven to bus driver BMB inputs.
REQ-011 bus_en  output  1  bus driver enable; high from LATCH through the last gap.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion strobe.
REQ-014 skip, ac_clr  output  1 each  latched device responses, valid while done is high and held until the next accepted iot_start.

Function
REQ-015 The FSM SHALL have states IDLE, LATCH, P1, G1, P2, G2, P4, G4, DONE, traversed strictly in that order.
REQ-016 In IDLE, iot_start=1 SHALL capture mb, clear skip and ac_clr, and move to LATCH on the next edge.
REQ-017 LATCH SHALL last exactly 1 cycle and drive dev_sel from the captured mb[8:3].
REQ-018 Each Px state SHALL last PULSE_CYC cycles; each Gx state SHALL last GAP_CYC cycles.
REQ-019 iopN SHALL be high only in state PN, and only if its captured enable bit is 1; a disabled slot still consumes its full time.
REQ-020 Timing SHALL be fixed: iot_start accepted at edge 0 -> done high for exactly one cycle, 2+3*(PULSE_CYC+GAP_CYC) cycles later; 20 cycles at defaults.
REQ-021 DONE SHALL last 1 cycle, assert done, and return to IDLE.
REQ-022 skip SHALL be set if io_skip=1 on any cycle in which any iopN is high; the same rule applies to io_ac_clr setting ac_clr; both are sticky until the next accepted start.
REQ-023 io_skip and io_ac_clr SHALL be ignored outside asserted pulse cycles.
REQ-024 iot_start while busy=1, including during DONE, SHALL be ignored with no queuing.
REQ-025 mb changes after capture SHALL have no effect on dev_sel or pulse enables.
REQ-026 mb[2:0]=0 SHALL run the full sequence with no pulses and then assert done.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 SHALL immediately force IDLE; iop1/iop2/iop4, bus_en, busy, done, skip and ac_clr all 0; dev_sel 0.
REQ-029 Reset mid-sequence SHALL abort without asserting done; after rst falls, the first accepted iot_start starts a fresh sequence.

Structure
REQ-030 Shared package iop_pkg SHALL hold the state enumeration, default PULSE_CYC/GAP_CYC constants, and the mb field bit positions.
REQ-031 One sub-module, iop_slot_timer (4-bit loadable down-counter with a zero flag), SHALL time the P and G states.

Verification
REQ-032 mb=9'o037 (dev 03, IOP1+2+4), defaults -> three 4-cycle pulses separated by 2-cycle gaps, done at cycle 20, dev_sel=6'o03 throughout.
REQ-033 mb=9'o412 (IOP2 only) with io_skip=1 during the IOP2 pulse -> only iop2 pulses; skip=1 at done; ac_clr=0.
REQ-034 io_skip=1 only during G1 and IDLE -> skip=0 at done.
REQ-035 Second iot_start at cycle 5 and again during DONE -> ignored; exactly one done strobe; a start in the following IDLE cycle is accepted.
REQ-036 rst pulsed during P2 -> all outputs 0 within the same cycle, no done; a new start then gives normal timing.
REQ-037 mb[2:0]=0 with PULSE_CYC=1, GAP_CYC=1 -> no pulses, bus_en high cycles 1..7, done at cycle 8.
